// File: rtl/fp_norm_pack_pkg.sv
// fp_norm_pack_pkg: shared types, constants and field helpers for the FP add/sub post-adder stage
package fp_norm_pack_pkg;
  localparam int MANT_W = 24;
  localparam int EXP_W = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  typedef enum logic [1:0] {IDLE, SEL, NORM, DONE} state_t;
  typedef struct packed {
    logic s;
    logic [EXP_W-1:0] e;
    logic [MANT_W-2:0] f;
  } fp_t;
  // e is 10-bit two's complement so underflow below 1 stays visible
  typedef struct packed {
    logic s;
    logic [EXP_W+1:0] e;
    logic [MANT_W-1:0] m;
  } res_t;
  function automatic logic is_nan(fp_t x);
    return x.e == EXP_MAX && x.f != '0;
  endfunction
  function automatic logic is_inf(fp_t x);
    return x.e == EXP_MAX && x.f == '0;
  endfunction
  function automatic logic is_zero(fp_t x);
    return x.e == '0;
  endfunction
  function automatic res_t mk_res(logic s, logic [EXP_W-1:0] e, logic [MANT_W-1:0] m);
    return '{s: s, e: {2'b00, e}, m: m};
  endfunction
endpackage

// File: rtl/fp_norm_pack_cand_select.sv
// fp_norm_pack_cand_select: picks the adder candidate for operand order and effective op, then resolves carry/borrow
module fp_norm_pack_cand_select
  import fp_norm_pack_pkg::*;
(
  input  fp_t                    a,
  input  fp_t                    b,
  input  logic                   op,
  input  logic [7:0][MANT_W-1:0] f,
  input  logic [7:0]             cy,
  output logic                   a_ge,
  output logic                   eff_sub,
  output logic                   s_b,
  output logic                   s_l,
  output logic [EXP_W-1:0]       e_l,
  output logic [EXP_W-1:0]       d_e,
  output logic [MANT_W-1:0]      m,
  output logic                   s,
  output logic                   inc
);
  logic [2:0] idx;
  logic [MANT_W-1:0] cand;
  logic c;
  always_comb begin
    a_ge = a.e >= b.e;
    s_b = b.s ^ op;
    eff_sub = a.s ^ s_b;
    s_l = a_ge ? a.s : s_b;
    e_l = a_ge ? a.e : b.e;
    d_e = a_ge ? a.e - b.e : b.e - a.e;
    // index 0..3 = f1..f4 (A larger), 4..7 = f5..f8 (B larger)
    idx = {~a_ge, s_l ^ eff_sub, eff_sub};
    cand = f[idx];
    c = cy[idx];
    inc = c & ~eff_sub;
    m = inc ? {1'b1, cand[MANT_W-1:1]} : (c & eff_sub) ? -cand : cand;
    s = (c & eff_sub) ? ~s_l : s_l;
  end
endmodule

// File: rtl/fp_norm_pack.sv
// fp_norm_pack: selects the adder candidate, handles specials, normalises one bit per cycle and packs an IEEE-754 single
module fp_norm_pack
  import fp_norm_pack_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_op,
  input  logic [23:0] in_f1,
  input  logic [23:0] in_f2,
  input  logic [23:0] in_f3,
  input  logic [23:0] in_f4,
  input  logic [23:0] in_f5,
  input  logic [23:0] in_f6,
  input  logic [23:0] in_f7,
  input  logic [23:0] in_f8,
  input  logic [7:0]  in_cy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);
  state_t state_q, state_d;
  fp_t a_q, a_d, b_q, b_d;
  logic op_q, op_d;
  logic [7:0][MANT_W-1:0] f_q, f_d;
  logic [7:0] cy_q, cy_d;
  res_t r_q, r_d;
  logic a_ge, eff_sub, s_b, s_l, s_m, inc, norm_ok, flush;
  logic [EXP_W-1:0] e_l, d_e;
  logic [MANT_W-1:0] m, m_sh;
  logic [EXP_W+1:0] e_inc, e_dec;
  fp_norm_pack_cand_select u_sel (
    .a       (a_q),
    .b       (b_q),
    .op      (op_q),
    .f       (f_q),
    .cy      (cy_q),
    .a_ge    (a_ge),
    .eff_sub (eff_sub),
    .s_b     (s_b),
    .s_l     (s_l),
    .e_l     (e_l),
    .d_e     (d_e),
    .m       (m),
    .s       (s_m),
    .inc     (inc)
  );
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_data = {r_q.s, r_q.e[EXP_W-1:0], r_q.m[MANT_W-2:0]};
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    f_d = f_q;
    cy_d = cy_q;
    r_d = r_q;
    e_inc = {2'b00, e_l} + {9'd0, inc};
    m_sh = r_q.m << 1;
    e_dec = r_q.e - 10'd1;
    norm_ok = m_sh[MANT_W-1] && $signed(e_dec) >= 10'sd1;
    flush = !norm_ok && $signed(e_dec) <= 10'sd1;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = in_a;
        b_d = in_b;
        op_d = in_op;
        f_d = {in_f8, in_f7, in_f6, in_f5, in_f4, in_f3, in_f2, in_f1};
        cy_d = in_cy;
        state_d = SEL;
      end
      SEL: begin
        state_d = DONE;
        if (is_nan(a_q) || is_nan(b_q) || (is_inf(a_q) && is_inf(b_q) && eff_sub))
          r_d = mk_res(QNAN[31], QNAN[30:23], {1'b0, QNAN[22:0]});
        else if (is_inf(a_q))
          r_d = mk_res(a_q.s, EXP_MAX, '0);
        else if (is_inf(b_q))
          r_d = mk_res(s_b, EXP_MAX, '0);
        else if (is_zero(a_q) && is_zero(b_q))
          r_d = '0;
        else if (is_zero(a_q))
          r_d = mk_res(s_b, b_q.e, {1'b1, b_q.f});
        else if (is_zero(b_q))
          r_d = mk_res(a_q.s, a_q.e, {1'b1, a_q.f});
        else if (d_e >= 8'd24)
          r_d = a_ge ? mk_res(s_l, a_q.e, {1'b1, a_q.f}) : mk_res(s_l, b_q.e, {1'b1, b_q.f});
        else if (e_inc == 10'd255)
          r_d = mk_res(s_m, EXP_MAX, '0);
        else if (m == '0)
          r_d = '0;
        else begin
          r_d = res_t'{s: s_m, e: e_inc, m: m};
          state_d = m[MANT_W-1] ? DONE : NORM;
        end
      end
      NORM: begin
        r_d = flush ? res_t'{s: r_q.s, e: '0, m: '0} : res_t'{s: r_q.s, e: e_dec, m: m_sh};
        state_d = (norm_ok || flush) ? DONE : NORM;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= 1'b0;
      f_q <= '0;
      cy_q <= '0;
      r_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      f_q <= f_d;
      cy_q <= cy_d;
      r_q <= r_d;
    end
endmodule

// File: tb/tb_fp_norm_pack.sv
// tb_fp_norm_pack: directed and random checks of fp_norm_pack against an integer-arithmetic reference
module tb_fp_norm_pack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic in_op = 1'b0;
  logic [23:0] in_f1 = '0, in_f2 = '0, in_f3 = '0, in_f4 = '0;
  logic [23:0] in_f5 = '0, in_f6 = '0, in_f7 = '0, in_f8 = '0;
  logic [7:0] in_cy = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [31:0] out_data;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_norm_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_f1     (in_f1),
    .in_f2     (in_f2),
    .in_f3     (in_f3),
    .in_f4     (in_f4),
    .in_f5     (in_f5),
    .in_f6     (in_f6),
    .in_f7     (in_f7),
    .in_f8     (in_f8),
    .in_cy     (in_cy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  // upstream adder model: aligned significand sums/differences with carry or borrow
  task automatic make_cands(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, d;
    logic [23:0] ma, mb, sha, shb;
    logic [24:0] sa, da, sb, db;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    d = (ea >= eb) ? ea - eb : eb - ea;
    ma = {1'b1, a[22:0]};
    mb = {1'b1, b[22:0]};
    shb = (d >= 24) ? 24'd0 : mb >> d;
    sha = (d >= 24) ? 24'd0 : ma >> d;
    sa = {1'b0, ma} + {1'b0, shb};
    da = {1'b0, ma} - {1'b0, shb};
    sb = {1'b0, mb} + {1'b0, sha};
    db = {1'b0, mb} - {1'b0, sha};
    in_f1 = sa[23:0];
    in_f3 = sa[23:0];
    in_f2 = da[23:0];
    in_f4 = da[23:0];
    in_f5 = sb[23:0];
    in_f7 = sb[23:0];
    in_f6 = db[23:0];
    in_f8 = db[23:0];
    in_cy = {db[24], sb[24], db[24], sb[24], da[24], sa[24], da[24], sa[24]};
  endtask

  function automatic logic [31:0] ref_fp(input logic [31:0] a, input logic [31:0] b, input logic op);
    int ea, eb, d, e;
    logic sa, sb, sl, s, eff, ag;
    longint ml, ms, v;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sa = a[31];
    sb = b[31] ^ op;
    eff = sa ^ sb;
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
    if (ea == 255 && eb == 255) return eff ? 32'h7FC00000 : {sa, 8'hFF, 23'd0};
    if (ea == 255) return {sa, 8'hFF, 23'd0};
    if (eb == 255) return {sb, 8'hFF, 23'd0};
    if (ea == 0 && eb == 0) return 32'd0;
    if (ea == 0) return {sb, b[30:0]};
    if (eb == 0) return a;
    ag = ea >= eb;
    d = ag ? ea - eb : eb - ea;
    if (d >= 24) return ag ? a : {sb, b[30:0]};
    ml = ag ? longint'({1'b1, a[22:0]}) : longint'({1'b1, b[22:0]});
    ms = (ag ? longint'({1'b1, b[22:0]}) : longint'({1'b1, a[22:0]})) >> d;
    sl = ag ? sa : sb;
    e = ag ? ea : eb;
    v = eff ? ml - ms : ml + ms;
    s = sl;
    if (v < 0) begin
      v = -v;
      s = ~sl;
    end
    if (v == 0) return 32'd0;
    if (v >= (64'sd1 << 24)) begin
      v = v >> 1;
      e++;
      if (e == 255) return {s, 8'hFF, 23'd0};
    end
    while (v < (64'sd1 << 23)) begin
      v = v << 1;
      e--;
    end
    if (e < 1) return {s, 31'd0};
    return {s, e[7:0], v[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [31:0] expv, input int exp_lat, input int hold, input string tag);
    int lat;
    @(negedge clk);
    make_cands(a, b);
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    if (exp_lat >= 0) chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk(tag, out_data, expv);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, out_data, expv);
      chk({tag, "_hrdy"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic rop, seen;
    int ea, eb;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    run_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 2, 0, "add_one_one");
    run_op(32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 4, 0, "sub_norm2");
    run_op(32'h3FA00000, 32'h3FC00000, 1'b1, 32'hBE800000, 4, 0, "sub_borrow");
    run_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 2, 0, "sub_to_zero");
    run_op(32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 2, 0, "de24");
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2, 0, "ovf_inf");
    run_op(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2, 0, "inf_minus_inf");
    run_op(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 2, 0, "nan_in");
    run_op(32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 2, 0, "zero_a");
    run_op(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 25, 0, "sub_lz23");
    run_op(32'h00C00000, 32'h00A00000, 1'b1, 32'h00000000, 3, 0, "flush_pos");
    run_op(32'h00A00000, 32'h00C00000, 1'b1, 32'h80000000, 3, 0, "flush_neg");
    run_op(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 2, 5, "backpressure");
    // abort an operation mid-normalisation
    @(negedge clk);
    make_cands(32'h3F800001, 32'h3F800000);
    in_a = 32'h3F800001;
    in_b = 32'h3F800000;
    in_op = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_norm_vld", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_norm_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_norm_vld2", {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("rst_no_output", {31'd0, seen}, 32'd0);
    run_op(32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 4, 0, "after_rst");
    for (int n = 0; n < 300; n++) begin
      ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 254));
      if ($urandom_range(0, 3) == 0)
        eb = int'($urandom_range(0, 255));
      else begin
        eb = ea + int'($urandom_range(0, 6)) - 3;
        if (eb < 1) eb = 1;
        if (eb > 254) eb = 254;
      end
      case ($urandom_range(0, 15))
        0: ea = 0;
        1: ea = 255;
        default: ;
      endcase
      ra = $urandom;
      rb = $urandom;
      ra[30:23] = ea[7:0];
      rb[30:23] = eb[7:0];
      if ($urandom_range(0, 2) == 0) rb[22:0] = ra[22:0] ^ 23'($urandom_range(0, 255));
      rop = 1'($urandom_range(0, 1));
      run_op(ra, rb, rop, ref_fp(ra, rb, rop), -1, ($urandom_range(0, 7) == 0) ? 2 : 0,
             $sformatf("rnd%0d_%h_%h_%0d", n, ra, rb, rop));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
